// File: rtl/dmem_arbiter_if.sv
// Shared data-memory port bundle: CPU load/store, DMA burst control and
// streams, and the WE/A/WD/RD pins of data_mem.
interface dmem_arbiter_if;
   logic            cpu_req;
   logic            cpu_we;
   logic [16:0]     cpu_addr;
   logic [5:0][7:0] cpu_wd;
   logic            cpu_gnt;
   logic [5:0][7:0] cpu_rd;

   logic            dma_start;
   logic            dma_dir;
   logic [16:0]     dma_base;
   logic [14:0]     dma_len;
   logic            dma_in_valid;
   logic [5:0][7:0] dma_in_data;
   logic            dma_in_ready;
   logic            dma_out_valid;
   logic [5:0][7:0] dma_out_data;
   logic            dma_out_ready;
   logic            dma_busy;
   logic            dma_done;

   logic            mem_we;
   logic [16:0]     mem_a;
   logic [5:0][7:0] mem_wd;
   logic [5:0][7:0] mem_rd;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wd,
      output cpu_gnt, cpu_rd,
      input  dma_start, dma_dir, dma_base, dma_len,
      input  dma_in_valid, dma_in_data,
      output dma_in_ready,
      output dma_out_valid, dma_out_data,
      input  dma_out_ready,
      output dma_busy, dma_done,
      output mem_we, mem_a, mem_wd,
      input  mem_rd
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wd,
      input  cpu_gnt, cpu_rd,
      output dma_start, dma_dir, dma_base, dma_len,
      output dma_in_valid, dma_in_data,
      input  dma_in_ready,
      input  dma_out_valid, dma_out_data,
      output dma_out_ready,
      input  dma_busy, dma_done,
      input  mem_we, mem_a, mem_wd,
      output mem_rd
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data_mem arbiter: CPU has priority, burst DMA gets a
// guaranteed slot after CPU_STREAK consecutive CPU grants.
module dmem_arbiter #(
   parameter int unsigned CPU_STREAK = 4
) (
   input logic           clk,
   input logic           rst_n,
   dmem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   localparam logic [3:0] STREAK_MAX = 4'(CPU_STREAK);

   state_t          state;
   logic [3:0]      streak;
   logic [16:0]     addr;
   logic [14:0]     remain;
   logic            out_valid;
   logic [5:0][7:0] out_data;
   logic            done;

   logic            dma_want;
   logic            dma_win;
   logic            cpu_gnt;
   logic            mem_we;
   logic [16:0]     mem_a;
   logic [5:0][7:0] mem_wd;

   always_comb begin
      dma_want = 1'b0;
      unique case (state)
         WRITE:   dma_want = bus.dma_in_valid;
         READ:    dma_want = !out_valid || bus.dma_out_ready;
         default: dma_want = 1'b0;
      endcase
   end

   // rst_n gate keeps the CPU from reaching memory while held in reset
   assign dma_win = dma_want && (!bus.cpu_req || streak == STREAK_MAX);
   assign cpu_gnt = rst_n && bus.cpu_req && !dma_win;

   always_comb begin
      mem_we = 1'b0;
      mem_a  = '0;
      mem_wd = '0;
      unique case (1'b1)
         cpu_gnt: begin
            mem_we = bus.cpu_we;
            mem_a  = bus.cpu_addr;
            mem_wd = bus.cpu_wd;
         end
         dma_win: begin
            mem_we = (state == WRITE);
            mem_a  = addr;
            mem_wd = bus.dma_in_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         streak    <= '0;
         addr      <= '0;
         remain    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;

         if (dma_win || !dma_want)
            streak <= '0;
         else if (cpu_gnt && streak != STREAK_MAX)
            streak <= streak + 4'd1;

         if (state == READ && dma_win) begin
            out_data  <= bus.mem_rd;
            out_valid <= 1'b1;
         end else if (bus.dma_out_ready) begin
            out_valid <= 1'b0;
         end

         if (dma_win) begin
            addr   <= addr + 17'd4;
            remain <= remain - 15'd1;
         end

         unique case (state)
            IDLE: begin
               if (bus.dma_start) begin
                  addr   <= {bus.dma_base[16:2], 2'b00};
                  remain <= bus.dma_len;
                  if (bus.dma_len == '0)
                     done <= 1'b1;
                  else
                     state <= bus.dma_dir ? WRITE : READ;
               end
            end
            WRITE: begin
               if (dma_win && remain == 15'd1) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            READ: begin
               if (dma_win && remain == 15'd1)
                  state <= DRAIN;
            end
            DRAIN: begin
               if (out_valid && bus.dma_out_ready) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cpu_gnt       = cpu_gnt;
   assign bus.cpu_rd        = bus.mem_rd;
   assign bus.dma_in_ready  = dma_win && (state == WRITE);
   assign bus.dma_out_valid = out_valid;
   assign bus.dma_out_data  = out_data;
   assign bus.dma_busy      = (state != IDLE);
   assign bus.dma_done      = done;
   assign bus.mem_we        = mem_we;
   assign bus.mem_a         = mem_a;
   assign bus.mem_wd        = mem_wd;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: cycle table for CPU/DMA/starvation,
// hand sequences for read backpressure, edge cases and mid-burst reset.
module tb_dmem_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   dmem_arbiter_if bus ();

   dmem_arbiter #(.CPU_STREAK(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [47:0] mem [0:32767];

   assign bus.mem_rd = mem[bus.mem_a[16:2]];

   always @(posedge clk)
      if (bus.mem_we) mem[bus.mem_a[16:2]] <= bus.mem_wd;

   localparam logic [47:0] S0 = 48'h0A0B0C0D0E0F;
   localparam logic [47:0] W0 = 48'h111122223333;
   localparam logic [47:0] W1 = 48'h444455556666;
   localparam logic [47:0] D1 = 48'hD1D1D1D1D1D1;
   localparam logic [47:0] D2 = 48'hD2D2D2D2D2D2;
   localparam logic [47:0] D3 = 48'hD3D3D3D3D3D3;
   localparam logic [47:0] D4 = 48'hD4D4D4D4D4D4;
   localparam logic [47:0] D5 = 48'hD5D5D5D5D5D5;
   localparam logic [47:0] D6 = 48'hD6D6D6D6D6D6;
   localparam logic [47:0] D7 = 48'hD7D7D7D7D7D7;
   localparam logic [47:0] D9 = 48'hD9D9D9D9D9D9;

   typedef struct {
      logic        cpu_req;
      logic        cpu_we;
      logic [16:0] cpu_addr;
      logic [47:0] cpu_wd;
      logic        start;
      logic        dir;
      logic [16:0] base;
      logic [14:0] len;
      logic        in_valid;
      logic [47:0] in_data;
      logic        out_ready;
      logic        e_gnt;
      logic        e_we;
      logic [16:0] e_a;
      logic        e_busy;
      logic        e_done;
      logic        e_inr;
   } vec_t;

   vec_t tbl [0:39];
   int   ntbl = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.cpu_req       = 1'b0;
      bus.cpu_we        = 1'b0;
      bus.cpu_addr      = '0;
      bus.cpu_wd        = '0;
      bus.dma_start     = 1'b0;
      bus.dma_dir       = 1'b0;
      bus.dma_base      = '0;
      bus.dma_len       = '0;
      bus.dma_in_valid  = 1'b0;
      bus.dma_in_data   = '0;
      bus.dma_out_ready = 1'b0;
   endtask

   task automatic start_dma(input logic dir, input logic [16:0] base,
                            input logic [14:0] len);
      bus.dma_start = 1'b1;
      bus.dma_dir   = dir;
      bus.dma_base  = base;
      bus.dma_len   = len;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t r;
      for (int i = 0; i < 32768; i++) mem[i] <= '0;
      idle_inputs();

      // table: CPU only, DMA write, starvation pattern
      tbl[ntbl] = '{'1,'1,17'h10,S0, '0,'0,'0,'0, '0,'0,'0,
                    '1,'1,17'h10,'0,'0,'0}; ntbl++;
      tbl[ntbl] = '{'1,'0,17'h10,'0, '0,'0,'0,'0, '0,'0,'0,
                    '1,'0,17'h10,'0,'0,'0}; ntbl++;
      tbl[ntbl] = '{'1,'1,17'h200,W0, '0,'0,'0,'0, '0,'0,'0,
                    '1,'1,17'h200,'0,'0,'0}; ntbl++;
      tbl[ntbl] = '{'1,'1,17'h204,W1, '0,'0,'0,'0, '0,'0,'0,
                    '1,'1,17'h204,'0,'0,'0}; ntbl++;
      tbl[ntbl] = '{'0,'0,'0,'0, '1,'1,17'h100,15'd3, '1,D1,'0,
                    '0,'0,'0,'0,'0,'0}; ntbl++;
      tbl[ntbl] = '{'0,'0,'0,'0, '0,'0,'0,'0, '1,D1,'0,
                    '0,'1,17'h100,'1,'0,'1}; ntbl++;
      tbl[ntbl] = '{'0,'0,'0,'0, '0,'0,'0,'0, '1,D2,'0,
                    '0,'1,17'h104,'1,'0,'1}; ntbl++;
      tbl[ntbl] = '{'0,'0,'0,'0, '0,'0,'0,'0, '1,D3,'0,
                    '0,'1,17'h108,'1,'0,'1}; ntbl++;
      tbl[ntbl] = '{'0,'0,'0,'0, '0,'0,'0,'0, '0,'0,'0,
                    '0,'0,'0,'0,'1,'0}; ntbl++;
      tbl[ntbl] = '{'0,'0,'0,'0, '0,'0,'0,'0, '0,'0,'0,
                    '0,'0,'0,'0,'0,'0}; ntbl++;
      tbl[ntbl] = '{'1,'0,17'h10,'0, '1,'1,17'h300,15'd3, '0,'0,'0,
                    '1,'0,17'h10,'0,'0,'0}; ntbl++;
      for (int k = 0; k < 15; k++) begin
         r = '{'1,'0,17'h10,'0, '0,'0,'0,'0, '1,D4,'0,
               '1,'0,17'h10,'1,'0,'0};
         if (k % 5 == 4) begin
            r.e_gnt = 1'b0;
            r.e_we  = 1'b1;
            r.e_a   = 17'h300 + 17'(4 * (k / 5));
            r.e_inr = 1'b1;
         end
         tbl[ntbl] = r;
         ntbl++;
      end
      tbl[ntbl] = '{'1,'0,17'h10,'0, '0,'0,'0,'0, '0,'0,'0,
                    '1,'0,17'h10,'0,'1,'0}; ntbl++;
      tbl[ntbl] = '{'0,'0,'0,'0, '0,'0,'0,'0, '0,'0,'0,
                    '0,'0,'0,'0,'0,'0}; ntbl++;

      // reset state while a CPU store is requested
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b1;
      bus.cpu_addr = 17'h10;
      bus.cpu_wd   = D7;
      #1 rst_n = 1'b0;
      #2;
      chk("rst gnt", 64'(bus.cpu_gnt), 64'(0));
      chk("rst mem_we", 64'(bus.mem_we), 64'(0));
      chk("rst busy", 64'(bus.dma_busy), 64'(0));
      chk("rst done", 64'(bus.dma_done), 64'(0));
      chk("rst oval", 64'(bus.dma_out_valid), 64'(0));
      chk("rst odata", 64'(bus.dma_out_data), 64'(0));
      chk("rst inr", 64'(bus.dma_in_ready), 64'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle_inputs();
      nxt();

      for (int i = 0; i < ntbl; i++) begin
         bus.cpu_req       = tbl[i].cpu_req;
         bus.cpu_we        = tbl[i].cpu_we;
         bus.cpu_addr      = tbl[i].cpu_addr;
         bus.cpu_wd        = tbl[i].cpu_wd;
         bus.dma_start     = tbl[i].start;
         bus.dma_dir       = tbl[i].dir;
         bus.dma_base      = tbl[i].base;
         bus.dma_len       = tbl[i].len;
         bus.dma_in_valid  = tbl[i].in_valid;
         bus.dma_in_data   = tbl[i].in_data;
         bus.dma_out_ready = tbl[i].out_ready;
         settle();
         chk($sformatf("t%0d gnt", i), 64'(bus.cpu_gnt), 64'(tbl[i].e_gnt));
         chk($sformatf("t%0d we", i), 64'(bus.mem_we), 64'(tbl[i].e_we));
         chk($sformatf("t%0d a", i), 64'(bus.mem_a), 64'(tbl[i].e_a));
         chk($sformatf("t%0d busy", i), 64'(bus.dma_busy), 64'(tbl[i].e_busy));
         chk($sformatf("t%0d done", i), 64'(bus.dma_done), 64'(tbl[i].e_done));
         chk($sformatf("t%0d inr", i), 64'(bus.dma_in_ready), 64'(tbl[i].e_inr));
         if (tbl[i].e_gnt && !tbl[i].cpu_we && tbl[i].cpu_addr == 17'h10)
            chk($sformatf("t%0d cpu_rd", i), 64'(bus.cpu_rd), 64'(S0));
         nxt();
      end
      idle_inputs();
      chk("mem 0x100", 64'(mem[15'h40]), 64'(D1));
      chk("mem 0x104", 64'(mem[15'h41]), 64'(D2));
      chk("mem 0x108", 64'(mem[15'h42]), 64'(D3));
      chk("mem 0x308", 64'(mem[15'hC2]), 64'(D4));

      // DMA read with backpressure on the first word
      start_dma(1'b0, 17'h200, 15'd2);
      settle();
      chk("rd start busy", 64'(bus.dma_busy), 64'(0));
      nxt();
      bus.dma_start = 1'b0;
      settle();
      chk("rd1 a", 64'(bus.mem_a), 64'(17'h200));
      chk("rd1 we", 64'(bus.mem_we), 64'(0));
      chk("rd1 oval", 64'(bus.dma_out_valid), 64'(0));
      for (int s = 0; s < 3; s++) begin
         nxt();
         settle();
         chk($sformatf("rd stall%0d a", s), 64'(bus.mem_a), 64'(0));
         chk($sformatf("rd stall%0d oval", s), 64'(bus.dma_out_valid), 64'(1));
         chk($sformatf("rd stall%0d data", s), 64'(bus.dma_out_data), 64'(W0));
      end
      nxt();
      bus.dma_out_ready = 1'b1;
      settle();
      chk("rd2 a", 64'(bus.mem_a), 64'(17'h204));
      nxt();
      settle();
      chk("rd drain data", 64'(bus.dma_out_data), 64'(W1));
      chk("rd drain oval", 64'(bus.dma_out_valid), 64'(1));
      chk("rd drain busy", 64'(bus.dma_busy), 64'(1));
      chk("rd drain done", 64'(bus.dma_done), 64'(0));
      nxt();
      settle();
      chk("rd done", 64'(bus.dma_done), 64'(1));
      chk("rd done busy", 64'(bus.dma_busy), 64'(0));
      chk("rd done oval", 64'(bus.dma_out_valid), 64'(0));
      nxt();
      idle_inputs();
      settle();
      chk("rd done low", 64'(bus.dma_done), 64'(0));

      // zero-length burst
      nxt();
      start_dma(1'b1, 17'h600, 15'd0);
      bus.dma_in_valid = 1'b1;
      bus.dma_in_data  = D7;
      settle();
      chk("len0 we", 64'(bus.mem_we), 64'(0));
      nxt();
      bus.dma_start = 1'b0;
      settle();
      chk("len0 done", 64'(bus.dma_done), 64'(1));
      chk("len0 busy", 64'(bus.dma_busy), 64'(0));
      chk("len0 we2", 64'(bus.mem_we), 64'(0));
      nxt();
      settle();
      chk("len0 done low", 64'(bus.dma_done), 64'(0));

      // address wrap at the top of the 17-bit space
      nxt();
      start_dma(1'b1, 17'h1FFFC, 15'd2);
      bus.dma_in_data = D5;
      nxt();
      bus.dma_start = 1'b0;
      settle();
      chk("wrap a0", 64'(bus.mem_a), 64'(17'h1FFFC));
      nxt();
      settle();
      chk("wrap a1", 64'(bus.mem_a), 64'(17'h00000));
      chk("wrap we1", 64'(bus.mem_we), 64'(1));
      nxt();
      settle();
      chk("wrap done", 64'(bus.dma_done), 64'(1));
      chk("wrap mem hi", 64'(mem[15'h7FFF]), 64'(D5));
      chk("wrap mem lo", 64'(mem[15'h0]), 64'(D5));

      // misaligned base drops the low address bits
      nxt();
      start_dma(1'b1, 17'h00103, 15'd1);
      bus.dma_in_data = D6;
      nxt();
      bus.dma_start = 1'b0;
      settle();
      chk("align a", 64'(bus.mem_a), 64'(17'h100));
      nxt();
      settle();
      chk("align done", 64'(bus.dma_done), 64'(1));
      chk("align mem", 64'(mem[15'h40]), 64'(D6));

      // reset after 2 of 5 words
      nxt();
      start_dma(1'b1, 17'h400, 15'd5);
      bus.dma_in_data = D7;
      nxt();
      bus.dma_start = 1'b0;
      settle();
      chk("mid w0 a", 64'(bus.mem_a), 64'(17'h400));
      nxt();
      settle();
      chk("mid w1 a", 64'(bus.mem_a), 64'(17'h404));
      nxt();
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b1;
      bus.cpu_addr = 17'h10;
      bus.cpu_wd   = D7;
      rst_n = 1'b0;
      #1;
      chk("mid rst busy", 64'(bus.dma_busy), 64'(0));
      chk("mid rst we", 64'(bus.mem_we), 64'(0));
      chk("mid rst inr", 64'(bus.dma_in_ready), 64'(0));
      chk("mid rst gnt", 64'(bus.cpu_gnt), 64'(0));
      chk("mid rst done", 64'(bus.dma_done), 64'(0));
      @(posedge clk);
      #1;
      chk("mid rst mem 0x408", 64'(mem[15'h102]), 64'(0));
      chk("mid rst mem 0x10", 64'(mem[15'h4]), 64'(S0));
      chk("mid rst mem 0x404", 64'(mem[15'h101]), 64'(D7));
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;
      nxt();
      settle();
      chk("post rst done", 64'(bus.dma_done), 64'(0));
      chk("post rst busy", 64'(bus.dma_busy), 64'(0));
      nxt();
      start_dma(1'b1, 17'h500, 15'd1);
      bus.dma_in_valid = 1'b1;
      bus.dma_in_data  = D9;
      nxt();
      bus.dma_start = 1'b0;
      settle();
      chk("new a", 64'(bus.mem_a), 64'(17'h500));
      chk("new we", 64'(bus.mem_we), 64'(1));
      nxt();
      settle();
      chk("new done", 64'(bus.dma_done), 64'(1));
      chk("new mem", 64'(mem[15'h140]), 64'(D9));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
